// File: rtl/dmem_store_monitor.sv
// Passive data-memory store monitor: buffers stores in an FWFT FIFO for in-order
// draining and decodes the end-of-test halt store (or a cycle timeout) into a verdict.
module dmem_store_monitor #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned HALT_ADDR = 63,
    parameter int unsigned TIMEOUT   = 200
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       d_mem_we,
    input  logic [ADDR_W-1:0]          d_mem_addr,
    input  logic [DATA_W-1:0]          d_mem_data,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [ADDR_W-1:0]          rd_addr,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic [7:0]                 fail_code,
    output logic [15:0]                cycle_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HALTED  = 2'd1,
        TIMEDOUT = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_e            state_q, state_d;
    logic [15:0]       cycle_q, cycle_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic [7:0]        code_q, code_d;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              is_halt_addr_c;
    logic              halt_store_c;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              wr_ok_c;
    entry_t            head_c;

    // Store classification; only RUN observes the bus.
    always_comb begin
        is_halt_addr_c = (d_mem_addr == ADDR_W'(HALT_ADDR));
        halt_store_c   = (state_q == RUN) && d_mem_we && is_halt_addr_c;
        push_c         = (state_q == RUN) && d_mem_we && !is_halt_addr_c;
        pop_c          = rd_en && (count_q != '0);
        full_c         = (count_q == CNT_W'(DEPTH));
        wr_ok_c        = push_c && (!full_c || pop_c);
    end

    // FIFO bookkeeping; a push into a full FIFO is kept only when a pop frees a slot.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (wr_ok_c) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({wr_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_c && !wr_ok_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage array needs no reset: the empty FIFO masks its contents.
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wptr_q] <= '{addr: d_mem_addr, data: d_mem_data};
        end
    end

    // Verdict FSM next-state; halt store wins over a coincident timeout.
    always_comb begin
        state_d = state_q;
        cycle_d = cycle_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        code_d  = code_q;
        case (state_q)
            RUN: begin
                if (cycle_q != 16'hFFFF) begin
                    cycle_d = cycle_q + 16'd1;
                end
                if (halt_store_c) begin
                    state_d = HALTED;
                    done_d  = 1'b1;
                    if (d_mem_data == DATA_W'(1)) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                        code_d = {1'b0, d_mem_data[7:1]};
                    end
                end else if (cycle_q == 16'(TIMEOUT - 1)) begin
                    state_d = TIMEDOUT;
                    done_d  = 1'b1;
                    fail_d  = 1'b1;
                    code_d  = 8'hFF;
                end
            end
            HALTED, TIMEDOUT: begin
                state_d = state_q;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cycle_q <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cycle_q <= cycle_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        head_c = mem_q[rptr_q];
    end

    assign rd_valid  = (count_q != '0);
    assign rd_addr   = rd_valid ? head_c.addr : '0;
    assign rd_data   = rd_valid ? head_c.data : '0;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign fail_code = code_q;
    assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_dmem_store_monitor.sv
// Randomized bench for dmem_store_monitor against a queue-based reference model;
// a second instance with a short timeout covers the timeout path.
module tb_dmem_store_monitor;

    localparam int unsigned HALT = 63;
    localparam int unsigned DEP  = 8;
    localparam int unsigned TMO  = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        d_mem_we = 1'b0;
    logic [5:0]  d_mem_addr = '0;
    logic [63:0] d_mem_data = '0;
    logic        rd_en = 1'b0;

    logic        rd_valid, overflow, done, pass, fail;
    logic [5:0]  rd_addr;
    logic [63:0] rd_data;
    logic [3:0]  count;
    logic [7:0]  fail_code;
    logic [15:0] cycle_cnt;

    logic        t_rd_valid, t_overflow, t_done, t_pass, t_fail;
    logic [5:0]  t_rd_addr;
    logic [63:0] t_rd_data;
    logic [3:0]  t_count;
    logic [7:0]  t_fail_code;
    logic [15:0] t_cycle_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [5:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    bit          m_ovf;
    bit          m_done, m_pass, m_fail;
    logic [7:0]  m_code;
    int          m_cyc;

    always #5 clk = ~clk;

    dmem_store_monitor #(.TIMEOUT(TMO)) u_dut (
        .clk(clk), .reset(reset), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr),
        .d_mem_data(d_mem_data), .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr),
        .rd_data(rd_data), .count(count), .overflow(overflow), .done(done), .pass(pass),
        .fail(fail), .fail_code(fail_code), .cycle_cnt(cycle_cnt)
    );

    dmem_store_monitor #(.TIMEOUT(20)) u_dut_to (
        .clk(clk), .reset(reset), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr),
        .d_mem_data(d_mem_data), .rd_en(rd_en), .rd_valid(t_rd_valid), .rd_addr(t_rd_addr),
        .rd_data(t_rd_data), .count(t_count), .overflow(t_overflow), .done(t_done),
        .pass(t_pass), .fail(t_fail), .fail_code(t_fail_code), .cycle_cnt(t_cycle_cnt)
    );

    // Behavioural model of one clock edge for the main instance.
    task automatic model_step(input bit we, input logic [5:0] a, input logic [63:0] d, input bit rd);
        int  old_cyc;
        bit  halt;
        bit  push;
        old_cyc = m_cyc;
        halt = !m_done && we && (a == 6'(HALT));
        push = !m_done && we && (a != 6'(HALT));
        if (rd && mq.size() > 0) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEP) mq.push_back('{a: a, d: d});
            else m_ovf = 1'b1;
        end
        if (!m_done) begin
            if (m_cyc < 65535) m_cyc = m_cyc + 1;
            if (halt) begin
                m_done = 1'b1;
                if (d == 64'd1) m_pass = 1'b1;
                else begin
                    m_fail = 1'b1;
                    m_code = {1'b0, d[7:1]};
                end
            end else if (old_cyc == TMO - 1) begin
                m_done = 1'b1;
                m_fail = 1'b1;
                m_code = 8'hFF;
            end
        end
    endtask

    task automatic cycle(input bit we, input logic [5:0] a, input logic [63:0] d, input bit rd);
        d_mem_we   = we;
        d_mem_addr = a;
        d_mem_data = d;
        rd_en      = rd;
        model_step(we, a, d, rd);
        @(posedge clk);
        #1;
        d_mem_we = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mq.delete();
        m_ovf = 0; m_done = 0; m_pass = 0; m_fail = 0; m_code = '0; m_cyc = 0;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({rd_valid, rd_addr, rd_data, count, overflow, done, pass, fail, fail_code, cycle_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%0b cnt=%0d done=%0b cyc=%0d, expected all zero",
                     rd_valid, count, done, cycle_cnt);
        end
        cycle(1'b0, '0, '0, 1'b1);
        n_checks++;
        if (rd_valid !== 1'b0 || count !== 4'd0 || cycle_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL pop_empty: got valid=%0b cnt=%0d cyc=%0d, expected 0/0/1", rd_valid, count, cycle_cnt);
        end
    endtask

    task automatic test_fifo_order();
        logic [5:0]  ea[3];
        logic [63:0] ed[3];
        ea = '{6'd2, 6'd5, 6'd7};
        ed = '{64'hA, 64'hB, 64'hC};
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, ea[i], ed[i], 1'b0);
        n_checks++;
        if (count !== 4'd3 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL order_count: got cnt=%0d valid=%0b, expected 3/1", count, rd_valid);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_addr !== ea[i] || rd_data !== ed[i] || mq[0].a !== ea[i]) begin
                n_fail++;
                $display("FAIL order_head%0d: got %0d/%0h, expected %0d/%0h", i, rd_addr, rd_data, ea[i], ed[i]);
            end
            cycle(1'b0, '0, '0, 1'b1);
        end
        n_checks++;
        if (rd_valid !== 1'b0 || rd_addr !== '0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL order_empty: got valid=%0b addr=%0d data=%0h, expected 0/0/0", rd_valid, rd_addr, rd_data);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 6'($urandom_range(62, 0)), {$urandom, $urandom}, 1'b0);
        n_checks++;
        if (count !== 4'd8 || overflow !== 1'b1 || int'(count) != mq.size()) begin
            n_fail++;
            $display("FAIL ovf_full: got cnt=%0d ovf=%0b, expected 8/1", count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_valid !== 1'b1 || rd_addr !== mq[0].a || rd_data !== mq[0].d) begin
                n_fail++;
                $display("FAIL ovf_drain%0d: got %0d/%0h, expected %0d/%0h", i, rd_addr, rd_data, mq[0].a, mq[0].d);
            end
            cycle(1'b0, '0, '0, 1'b1);
        end
        n_checks++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: got valid=%0b ovf=%0b, expected 0/1", rd_valid, overflow);
        end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 6'($urandom_range(62, 0)), {$urandom, $urandom}, 1'b0);
        cycle(1'b1, 6'd4, 64'h55, 1'b1);
        n_checks++;
        if (count !== 4'd8 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpp_count: got cnt=%0d ovf=%0b, expected 8/0", count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (rd_addr !== mq[0].a || rd_data !== mq[0].d) begin
                n_fail++;
                $display("FAIL fullpp_drain%0d: got %0d/%0h, expected %0d/%0h", i, rd_addr, rd_data, mq[0].a, mq[0].d);
            end
            if (i == 7) begin
                n_checks++;
                if (rd_addr !== 6'd4 || rd_data !== 64'h55) begin
                    n_fail++;
                    $display("FAIL fullpp_last: got %0d/%0h, expected 4/55", rd_addr, rd_data);
                end
            end
            cycle(1'b0, '0, '0, 1'b1);
        end
    endtask

    task automatic test_random_traffic();
        do_reset();
        for (int i = 0; i < 80; i++) begin
            cycle(1'($urandom_range(1, 0)), 6'($urandom_range(62, 0)), {$urandom, $urandom},
                  ($urandom_range(2, 0) == 0));
            n_checks++;
            if (int'(count) != mq.size() || overflow !== m_ovf || rd_valid !== (mq.size() != 0) ||
                (mq.size() != 0 && (rd_addr !== mq[0].a || rd_data !== mq[0].d))) begin
                n_fail++;
                $display("FAIL rand_cyc%0d: got cnt=%0d ovf=%0b addr=%0d, expected cnt=%0d ovf=%0b",
                         i, count, overflow, rd_addr, mq.size(), m_ovf);
            end
        end
        n_checks++;
        if (int'(cycle_cnt) != m_cyc || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_cycles: got cyc=%0d done=%0b, expected %0d/0", cycle_cnt, done, m_cyc);
        end
    endtask

    task automatic test_halt_pass();
        do_reset();
        for (int i = 0; i < 40; i++) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 6'(HALT), 64'd1, 1'b0);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0 || cycle_cnt !== 16'd41 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL halt_pass: got done=%0b pass=%0b fail=%0b cyc=%0d cnt=%0d, expected 1/1/0/41/0",
                     done, pass, fail, cycle_cnt, count);
        end
        cycle(1'b1, 6'd3, 64'h77, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (count !== 4'd0 || cycle_cnt !== 16'd41 || pass !== 1'b1 || int'(cycle_cnt) != m_cyc) begin
            n_fail++;
            $display("FAIL halt_frozen: got cnt=%0d cyc=%0d pass=%0b, expected 0/41/1", count, cycle_cnt, pass);
        end
    endtask

    task automatic test_halt_fail();
        logic [63:0] d;
        do_reset();
        cycle(1'b1, 6'd9, 64'h1234, 1'b0);
        cycle(1'b1, 6'(HALT), 64'h0B, 1'b0);
        n_checks++;
        if (done !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || fail_code !== 8'd5 || count !== 4'd1) begin
            n_fail++;
            $display("FAIL halt_fail: got done=%0b fail=%0b pass=%0b code=%0h cnt=%0d, expected 1/1/0/05/1",
                     done, fail, pass, fail_code, count);
        end
        cycle(1'b1, 6'(HALT), 64'd1, 1'b0);
        n_checks++;
        if (pass !== 1'b0 || fail_code !== 8'd5) begin
            n_fail++;
            $display("FAIL halt_sticky: got pass=%0b code=%0h, expected 0/05", pass, fail_code);
        end
        do_reset();
        d = {$urandom, $urandom} | 64'h100;
        cycle(1'b1, 6'(HALT), d, 1'b0);
        n_checks++;
        if (fail_code !== m_code || fail !== 1'b1 || fail_code !== {1'b0, d[7:1]}) begin
            n_fail++;
            $display("FAIL halt_code_rand: got %0h, expected %0h", fail_code, m_code);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        cycle(1'b1, 6'd10, 64'hAA, 1'b0);
        cycle(1'b1, 6'd11, 64'hBB, 1'b0);
        for (int i = 0; i < 17; i++) cycle(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (t_done !== 1'b0 || t_cycle_cnt !== 16'd19) begin
            n_fail++;
            $display("FAIL timeout_early: got done=%0b cyc=%0d, expected 0/19", t_done, t_cycle_cnt);
        end
        cycle(1'b0, '0, '0, 1'b0);
        n_checks++;
        if (t_done !== 1'b1 || t_fail !== 1'b1 || t_pass !== 1'b0 || t_fail_code !== 8'hFF ||
            t_cycle_cnt !== 16'd20 || t_count !== 4'd2) begin
            n_fail++;
            $display("FAIL timeout_hit: got done=%0b fail=%0b code=%0h cyc=%0d cnt=%0d, expected 1/1/ff/20/2",
                     t_done, t_fail, t_fail_code, t_cycle_cnt, t_count);
        end
        n_checks++;
        if (done !== 1'b0 || count !== 4'd2) begin
            n_fail++;
            $display("FAIL timeout_main: got done=%0b cnt=%0d, expected 0/2", done, count);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({t_rd_valid, t_rd_addr, t_rd_data, t_count, t_overflow, t_done, t_pass, t_fail,
             t_fail_code, t_cycle_cnt} !== '0 || count !== 4'd0) begin
            n_fail++;
            $display("FAIL timeout_reset: got done=%0b cnt=%0d code=%0h, expected all zero",
                     t_done, t_count, t_fail_code);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_overflow();
        test_full_push_pop();
        test_random_traffic();
        test_halt_pass();
        test_halt_fail();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
